// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared definitions for the load/store unit: RISC-V funct3 width
//             codes, FSM state encoding and a request legality helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // A request is legal when the width code exists for its direction, the
    // address is naturally aligned for that width, and it falls inside RAM.
    function automatic logic req_legal(input logic        we,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input logic [31:0] limit);
        logic ok_f3;
        logic ok_align;
        ok_f3    = 1'b0;
        ok_align = 1'b0;
        case (funct3)
            c_F3_B, c_F3_H, c_F3_W: ok_f3 = 1'b1;
            c_F3_BU, c_F3_HU:       ok_f3 = !we;  // no unsigned stores
            default:                ok_f3 = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00:   ok_align = 1'b1;
            2'b01:   ok_align = !addr[0];
            2'b10:   ok_align = (addr[1:0] == 2'b00);
            default: ok_align = 1'b0;
        endcase
        return ok_f3 && ok_align && (addr < limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if
//  Purpose  : Bundles the core request/response handshake and the data RAM
//             port of the load/store unit.
//  Ports    : req_*  core request (valid/ready, we, funct3, addr, wdata)
//             resp_* response (valid/ready, rdata, err)
//             mem_*  RAM port (addr, wdata, mask, we out; rdata in)
//             modport slave  : the load/store unit
//             modport master : the core + RAM environment
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_mask, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_mask, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational byte-lane logic: store mask/data replication and
//             load extraction with sign/zero extension.
//  Ports    : funct3_i  width code        offset_i  addr[1:0]
//             wdata_i   right-aligned store data
//             rdata_i   raw RAM word
//             mask_o    byte-lane mask    wdata_o   lane-replicated data
//             load_o    aligned, extended load result
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  wire logic [2:0]  funct3_i,
    input  wire logic [1:0]  offset_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic [31:0] rdata_i,
    output logic      [3:0]  mask_o,
    output logic      [31:0] wdata_o,
    output logic      [31:0] load_o
);

    logic [31:0] w_shifted;

    // Byte of interest is moved down to bit 0 before extension.
    assign w_shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        mask_o  = 4'b1111;
        wdata_o = wdata_i;
        // Data is replicated across lanes so the mask alone selects the bytes.
        case (funct3_i[1:0])
            2'b00: begin
                mask_o  = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                mask_o  = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_o = rdata_i;
        case (funct3_i)
            c_F3_B:  load_o = {{24{w_shifted[7]}},  w_shifted[7:0]};
            c_F3_H:  load_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_F3_BU: load_o = {24'd0, w_shifted[7:0]};
            c_F3_HU: load_o = {16'd0, w_shifted[15:0]};
            default: load_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Single-outstanding load/store unit between a RISC-V core and a
//             word-wide data RAM. IDLE accepts, ACCESS drives the RAM for one
//             cycle, RESP holds the response until the core takes it.
//  Ports    : clk    system clock
//             rst_n  synchronous active-low reset
//             bus    lsu_if.slave (core handshake + RAM port)
//  Params   : MEM_WORDS  number of 32-bit RAM words
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 128
)(
    input  wire logic clk,
    input  wire logic rst_n,
    lsu_if.slave      bus
);

    localparam logic [31:0] c_ADDR_LIMIT = 32'(4 * MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  w_mask;
    logic [31:0] w_wlanes;
    logic [31:0] w_load;

    lsu_align u_align (
        .funct3_i (f3_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (bus.mem_rdata),
        .mask_o   (w_mask),
        .wdata_o  (w_wlanes),
        .load_o   (w_load)
    );

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        f3_d           = f3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_wdata  = 32'd0;
        bus.mem_mask   = 4'b0000;
        bus.mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'd0;
                    if (req_legal(bus.req_we, bus.req_funct3, bus.req_addr, c_ADDR_LIMIT)) begin
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                bus.mem_addr  = {addr_q[31:2], 2'b00};
                bus.mem_mask  = w_mask;
                bus.mem_wdata = we_q ? w_wlanes : 32'd0;
                // Gating with rst_n keeps a reset in this cycle from
                // committing the write at the closing edge.
                bus.mem_we    = we_q & rst_n;
                rdata_d       = we_q ? 32'd0 : w_load;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 128, number of 32-bit words in the attached data RAM; byte addresses >= 4*MEM_WORDS are out of range.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core accepts the response.
REQ-012 resp_rdata  output  32  aligned, extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, illegal-funct3 or out-of-range request.
REQ-014 mem_addr  output  32  to RAM write/read port address.
REQ-015 mem_wdata  output  32  to RAM data input, byte-lane shifted.
REQ-016 mem_mask  output  4  to RAM byte-lane mask.
REQ-017 mem_we  output  1  to RAM write enable.
REQ-018 mem_rdata  input  32  from RAM read port, combinational on mem_addr.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-020 IDLE: on req_valid, latch request, then go to ACCESS if legal, else RESP with resp_err = 1.
REQ-021 Legal: H/HU with addr[0] = 0; W with addr[1:0] = 00; B/BU any; addr < 4*MEM_WORDS; funct3 in the listed set, with stores limited to 000/001/010.
REQ-022 ACCESS lasts exactly one cycle: mem_addr = latched addr with [1:0] cleared; for stores mem_we = 1; then go to RESP.
REQ-023 Store lanes: B mask = 0001 << addr[1:0], data = wdata[7:0] replicated in all four bytes; H mask = 0011 << addr[1:0], data = wdata[15:0] replicated; W mask = 1111, data = wdata.
REQ-024 Load: at end of ACCESS, register mem_rdata shifted right by 8*addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
REQ-025 RESP: resp_valid = 1, resp_rdata and resp_err stable; go to IDLE on resp_ready, else hold.
REQ-026 Latency: request accepted at edge N gives resp_valid high after edge N+2 for legal requests and after edge N+1 for errors.
REQ-027 mem_we = 1 only in ACCESS of a legal store, never on error; mem_mask = 0000 outside ACCESS.
REQ-028 No back-to-back acceptance: a new request is accepted one cycle after the response handshake at the earliest.

Reset
REQ-029 rst_n low at an edge: state IDLE; resp_valid, resp_err, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0; mem_mask = 0000.
REQ-030 Reset during ACCESS aborts the access, so no write occurs on the following edge, and the pending response is discarded.

Structure
REQ-031 Shared package lsu_pkg holds the funct3 width constants and the FSM state encoding.
REQ-032 One sub-module, lsu_align, holds the combinational store lane/mask generation and load extraction/extension.

Verification
REQ-033 SB addr 0x0000_0005, wdata 0x0000_00AB -> mem_we for one cycle, mem_mask 0010, mem_wdata 0xABABABAB, mem_addr 0x4, resp_err 0.
REQ-034 RAM word 0x4 = 0x80FF_1234; LB addr 0x6 -> resp_rdata 0xFFFF_FFFF; LBU -> 0x0000_00FF; LH addr 0x6 -> 0xFFFF_80FF.
REQ-035 LW addr 0x2 -> no ACCESS cycle, mem_we stays 0, resp_err 1, resp_rdata 0, response one cycle after acceptance.
REQ-036 SW addr 0x200 with MEM_WORDS 128 -> resp_err 1, no write.
REQ-037 resp_ready held low 5 cycles -> resp_valid and resp_rdata stable throughout, req_ready 0 throughout.
REQ-038 rst_n low in ACCESS cycle of a store -> state IDLE, mem_we 0 after the edge, RAM unchanged, no resp_valid.
